// File: rtl/seq_stage_controller.sv
// seq_stage_controller: top-level sequencer for a SEQ Y86-64 core.
// Walks one instruction at a time through FETCH, DECODE, EXECUTE, MEMORY,
// WRITEBACK and PC update. It owns the architectural PC, the status code,
// and the retired-instruction and cycle counters. Any fetch or data-memory
// fault, or a halt, parks the machine in STOP until the next start pulse.
module seq_stage_controller #(
  parameter logic [63:0] PC_RESET    = 64'd0,
  parameter logic [63:0] MEM_LIMIT   = 64'd2400,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  Ins_Code,
  input  logic        Cnd,
  input  logic [63:0] Val_P,
  input  logic [63:0] Val_C,
  input  logic [63:0] Val_M,
  input  logic        mem_invalid_check,
  input  logic        instruction_invalid_check,
  input  logic        func_invalid_check,
  input  logic        mem_ready,
  input  logic        dmem_error,
  output logic [63:0] PC_adress,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        execute_en,
  output logic        memory_en,
  output logic        writeback_en,
  output logic [1:0]  stat,
  output logic        running,
  output logic        done,
  output logic [63:0] instr_count,
  output logic [31:0] cycle_count,
  output logic [2:0]  state
);

  // Sequencer state encodings; these values are visible on the debug port.
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_PCUPD     = 3'd6;
  localparam logic [2:0] S_STOP      = 3'd7;

  // Y86-64 status codes.
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  // Instruction codes that redirect the PC.
  localparam logic [3:0] IC_HALT = 4'h0;
  localparam logic [3:0] IC_JXX  = 4'h7;
  localparam logic [3:0] IC_CALL = 4'h8;
  localparam logic [3:0] IC_RET  = 4'h9;

  // The wait counter must be able to hold MEM_TIMEOUT-1. One extra bit of
  // headroom keeps the width sensible for MEM_TIMEOUT values of 1 or 2.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  // Fault priority at decode: address error, then illegal code, then halt.
  function automatic logic [1:0] decode_status(
    input logic       adr_fault,
    input logic       ins_fault,
    input logic       fn_fault,
    input logic [3:0] icode
  );
    logic [1:0] result;
    if (adr_fault) begin
      result = STAT_ADR;
    end else if (ins_fault || fn_fault) begin
      result = STAT_INS;
    end else if (icode == IC_HALT) begin
      result = STAT_HLT;
    end else begin
      result = STAT_AOK;
    end
    return result;
  endfunction

  // New-PC selection: call and taken jumps go to the constant word, ret goes
  // to the popped return address, everything else falls through.
  function automatic logic [63:0] select_pc(
    input logic [3:0]  icode,
    input logic        cnd,
    input logic [63:0] valp,
    input logic [63:0] valc,
    input logic [63:0] valm
  );
    logic [63:0] result;
    if (icode == IC_CALL) begin
      result = valc;
    end else if ((icode == IC_JXX) && cnd) begin
      result = valc;
    end else if (icode == IC_RET) begin
      result = valm;
    end else begin
      result = valp;
    end
    return result;
  endfunction

  logic [1:0]        decode_stat;
  logic              decode_fault;
  logic [63:0]       new_pc;
  logic              pc_range_err;
  logic              mem_timeout;
  logic [WAIT_W-1:0] wait_cnt;

  logic [2:0] state_nxt;
  logic [1:0] stat_nxt;
  logic       restart;
  logic       pc_load;
  logic       retire;

  assign decode_stat  = decode_status(mem_invalid_check, instruction_invalid_check,
                                      func_invalid_check, Ins_Code);
  assign decode_fault = (decode_stat != STAT_AOK);
  assign new_pc       = select_pc(Ins_Code, Cnd, Val_P, Val_C, Val_M);
  assign pc_range_err = (new_pc > MEM_LIMIT);
  assign mem_timeout  = (wait_cnt == WAIT_LAST);

  // Stage enables decode straight from the state; a faulting decode never
  // reaches the register file, so decode_en drops in that same cycle.
  always_comb begin
    fetch_en     = (state == S_FETCH);
    decode_en    = (state == S_DECODE) && !decode_fault;
    execute_en   = (state == S_EXECUTE);
    memory_en    = (state == S_MEMORY);
    writeback_en = (state == S_WRITEBACK);
    running      = (state != S_IDLE) && (state != S_STOP);
    done         = (state == S_STOP);
  end

  // Next-state, status and PC/counter control for the instruction sequence.
  always_comb begin
    state_nxt = state;
    stat_nxt  = stat;
    restart   = 1'b0;
    pc_load   = 1'b0;
    retire    = 1'b0;
    case (state)
      S_IDLE, S_STOP: begin
        if (start) begin
          state_nxt = S_FETCH;
          stat_nxt  = STAT_AOK;
          restart   = 1'b1;
        end
      end
      S_FETCH: begin
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (decode_fault) begin
          stat_nxt  = decode_stat;
          state_nxt = S_STOP;
        end else begin
          state_nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_nxt = S_MEMORY;
      end
      S_MEMORY: begin
        if (mem_ready) begin
          if (dmem_error) begin
            stat_nxt  = STAT_ADR;
            state_nxt = S_STOP;
          end else begin
            state_nxt = S_WRITEBACK;
          end
        end else if (mem_timeout) begin
          stat_nxt  = STAT_ADR;
          state_nxt = S_STOP;
        end
      end
      S_WRITEBACK: begin
        state_nxt = S_PCUPD;
      end
      S_PCUPD: begin
        if (pc_range_err) begin
          stat_nxt  = STAT_ADR;
          state_nxt = S_STOP;
        end else begin
          pc_load   = 1'b1;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      stat  <= STAT_AOK;
    end else begin
      state <= state_nxt;
      stat  <= stat_nxt;
    end
  end

  // Architectural PC: loaded only on start or by a successful PC update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC_adress <= PC_RESET;
    end else if (restart) begin
      PC_adress <= PC_RESET;
    end else if (pc_load) begin
      PC_adress <= new_pc;
    end
  end

  // Retired-instruction counter; halted and faulting instructions never retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= 64'd0;
    end else if (restart) begin
      instr_count <= 64'd0;
    end else if (retire) begin
      instr_count <= instr_count + 64'd1;
    end
  end

  // Saturating cycle counter that advances on every running cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= 32'd0;
    end else if (restart) begin
      cycle_count <= 32'd0;
    end else if (running && (cycle_count != 32'hFFFF_FFFF)) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  // Memory wait counter: held at zero outside MEMORY so each visit starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != S_MEMORY) begin
      wait_cnt <= '0;
    end else if (!mem_ready && !mem_timeout) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_stage_controller.sv
// Testbench for seq_stage_controller: directed instructions with hand-computed
// results pushed to a scoreboard; a monitor pops one entry whenever the DUT
// finishes an instruction (returns to FETCH from PCUPD, or enters STOP).
module tb_seq_stage_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  Ins_Code;
  logic        Cnd;
  logic [63:0] Val_P;
  logic [63:0] Val_C;
  logic [63:0] Val_M;
  logic        mem_invalid_check;
  logic        instruction_invalid_check;
  logic        func_invalid_check;
  logic        mem_ready;
  logic        dmem_error;
  logic [63:0] PC_adress;
  logic        fetch_en;
  logic        decode_en;
  logic        execute_en;
  logic        memory_en;
  logic        writeback_en;
  logic [1:0]  stat;
  logic        running;
  logic        done;
  logic [63:0] instr_count;
  logic [31:0] cycle_count;
  logic [2:0]  state;

  always #5 clk = ~clk;

  seq_stage_controller dut (
    .clk                       (clk),
    .rst                       (rst),
    .start                     (start),
    .Ins_Code                  (Ins_Code),
    .Cnd                       (Cnd),
    .Val_P                     (Val_P),
    .Val_C                     (Val_C),
    .Val_M                     (Val_M),
    .mem_invalid_check         (mem_invalid_check),
    .instruction_invalid_check (instruction_invalid_check),
    .func_invalid_check        (func_invalid_check),
    .mem_ready                 (mem_ready),
    .dmem_error                (dmem_error),
    .PC_adress                 (PC_adress),
    .fetch_en                  (fetch_en),
    .decode_en                 (decode_en),
    .execute_en                (execute_en),
    .memory_en                 (memory_en),
    .writeback_en              (writeback_en),
    .stat                      (stat),
    .running                   (running),
    .done                      (done),
    .instr_count               (instr_count),
    .cycle_count               (cycle_count),
    .state                     (state)
  );

  typedef struct {
    logic [1:0]  stat;
    logic [63:0] pc;
    logic [63:0] icount;
    logic [31:0] ccount;
    logic        done;
    int          n_dec;
    int          n_exe;
    int          n_mem;
    int          n_wb;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_icount;
  logic [31:0] exp_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: per-instruction enable tallies, compared on each completion event.
  logic [2:0] prev_state = 3'd0;
  int a_fetch, a_dec, a_exe, a_mem, a_wb, a_multi;

  always @(negedge clk) begin
    if (state == 3'd0) begin
      a_fetch = 0; a_dec = 0; a_exe = 0; a_mem = 0; a_wb = 0; a_multi = 0;
    end else begin
      if ((state == 3'd7 && prev_state != 3'd7) || (state == 3'd1 && prev_state == 3'd6)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion state=%0d pc=0x%0h", state, PC_adress);
        end else begin
          mon_e = sb.pop_front();
          chk("stat", {62'd0, stat}, {62'd0, mon_e.stat});
          chk("pc", PC_adress, mon_e.pc);
          chk("instr_count", instr_count, mon_e.icount);
          chk("cycle_count", {32'd0, cycle_count}, {32'd0, mon_e.ccount});
          chk("done", {63'd0, done}, {63'd0, mon_e.done});
          chk("running", {63'd0, running}, {63'd0, !mon_e.done});
          chk("fetch_en_cycles", 64'(a_fetch), 64'd1);
          chk("decode_en_cycles", 64'(a_dec), 64'(mon_e.n_dec));
          chk("execute_en_cycles", 64'(a_exe), 64'(mon_e.n_exe));
          chk("memory_en_cycles", 64'(a_mem), 64'(mon_e.n_mem));
          chk("writeback_en_cycles", 64'(a_wb), 64'(mon_e.n_wb));
          chk("onehot_violations", 64'(a_multi), 64'd0);
        end
        a_fetch = 0; a_dec = 0; a_exe = 0; a_mem = 0; a_wb = 0; a_multi = 0;
      end
      a_fetch += int'(fetch_en);
      a_dec   += int'(decode_en);
      a_exe   += int'(execute_en);
      a_mem   += int'(memory_en);
      a_wb    += int'(writeback_en);
      if ($countones({fetch_en, decode_en, execute_en, memory_en, writeback_en}) > 1)
        a_multi++;
    end
    prev_state <= state;
  end

  // Pulse start from IDLE/STOP and confirm the restart values in FETCH.
  task automatic start_machine();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_icount = 64'd0;
    exp_cyc    = 32'd0;
    chk("start_state", {61'd0, state}, 64'd1);
    chk("start_pc", PC_adress, 64'd0);
    chk("start_stat", {62'd0, stat}, 64'd0);
    chk("start_instr_count", instr_count, 64'd0);
    chk("start_cycle_count", {32'd0, cycle_count}, 64'd0);
  endtask

  // Drive one instruction from a FETCH-cycle negedge until it completes.
  // kind: 0 = stops at decode, 1 = stops in memory, 2 = reaches PC update.
  task automatic run_instr(
    input logic [3:0]  ic,
    input logic        cn,
    input logic [63:0] vp,
    input logic [63:0] vc,
    input logic [63:0] vm,
    input logic [2:0]  flags,
    input logic        derr,
    input int          mem_wait,
    input int          kind,
    input int          xmem,
    input logic [1:0]  xstat,
    input logic [63:0] xpc
  );
    exp_t e;
    int   k;
    bit   finished;
    Ins_Code = ic;
    Cnd      = cn;
    Val_P    = vp;
    Val_C    = vc;
    Val_M    = vm;
    {mem_invalid_check, instruction_invalid_check, func_invalid_check} = flags;
    dmem_error = derr;
    if (kind == 0)      exp_cyc = exp_cyc + 32'd2;
    else if (kind == 1) exp_cyc = exp_cyc + 32'(3 + xmem);
    else                exp_cyc = exp_cyc + 32'(5 + xmem);
    if (kind == 2 && xstat == 2'd0) exp_icount = exp_icount + 64'd1;
    e.stat   = xstat;
    e.pc     = xpc;
    e.icount = exp_icount;
    e.ccount = exp_cyc;
    e.done   = (xstat != 2'd0);
    e.n_dec  = (kind == 0) ? 0 : 1;
    e.n_exe  = (kind == 0) ? 0 : 1;
    e.n_mem  = (kind == 0) ? 0 : xmem;
    e.n_wb   = (kind == 2) ? 1 : 0;
    sb.push_back(e);
    k = 0;
    finished = 1'b0;
    for (int i = 0; i < 60 && !finished; i++) begin
      @(negedge clk);
      mem_ready = memory_en && (k >= mem_wait);
      if (memory_en) k++;
      if (state == 3'd7 || state == 3'd1 || state == 3'd0) finished = 1'b1;
    end
    mem_ready = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL instr_timeout icode=%0d state=%0d expected=completion", ic, state);
    end
  endtask

  initial begin
    bit reached;
    rst = 1'b1;
    start = 1'b0;
    Ins_Code = 4'h1;
    Cnd = 1'b0;
    Val_P = 64'd0;
    Val_C = 64'd0;
    Val_M = 64'd0;
    mem_invalid_check = 1'b0;
    instruction_invalid_check = 1'b0;
    func_invalid_check = 1'b0;
    mem_ready = 1'b0;
    dmem_error = 1'b0;
    exp_icount = 64'd0;
    exp_cyc = 32'd0;

    #22;
    chk("reset_state", {61'd0, state}, 64'd0);
    chk("reset_pc", PC_adress, 64'd0);
    chk("reset_stat", {62'd0, stat}, 64'd0);
    chk("reset_enables", {59'd0, fetch_en, decode_en, execute_en, memory_en, writeback_en}, 64'd0);
    chk("reset_running_done", {62'd0, running, done}, 64'd0);
    chk("reset_counts", instr_count | {32'd0, cycle_count}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Straight-line flow and PC selection.
    start_machine();
    run_instr(4'h1, 1'b0, 64'h8,   64'h0,   64'h0,  3'b000, 1'b0, 0, 2, 1, 2'd0, 64'h8);
    run_instr(4'h7, 1'b0, 64'h48,  64'h40,  64'h0,  3'b000, 1'b0, 0, 2, 1, 2'd0, 64'h48);
    run_instr(4'h7, 1'b1, 64'h48,  64'h40,  64'h0,  3'b000, 1'b0, 0, 2, 1, 2'd0, 64'h40);
    run_instr(4'h8, 1'b0, 64'h4a,  64'h100, 64'h0,  3'b000, 1'b0, 0, 2, 1, 2'd0, 64'h100);
    run_instr(4'h9, 1'b0, 64'h101, 64'h0,   64'h88, 3'b000, 1'b0, 0, 2, 1, 2'd0, 64'h88);
    run_instr(4'h6, 1'b1, 64'h8a,  64'h500, 64'h0,  3'b000, 1'b0, 0, 2, 1, 2'd0, 64'h8a);
    // Memory wait of three cycles, then PC limit boundary and overflow.
    run_instr(4'h1, 1'b0, 64'h90,  64'h0,   64'h0,  3'b000, 1'b0, 3, 2, 4, 2'd0, 64'h90);
    run_instr(4'h1, 1'b0, 64'd2400, 64'h0,  64'h0,  3'b000, 1'b0, 0, 2, 1, 2'd0, 64'd2400);
    run_instr(4'h1, 1'b0, 64'd2401, 64'h0,  64'h0,  3'b000, 1'b0, 0, 2, 1, 2'd2, 64'd2400);

    // Halt keeps PC and count, then restart.
    start_machine();
    run_instr(4'h1, 1'b0, 64'h8,   64'h0,   64'h0,  3'b000, 1'b0, 0, 2, 1, 2'd0, 64'h8);
    run_instr(4'h0, 1'b0, 64'h9,   64'h0,   64'h0,  3'b000, 1'b0, 0, 0, 0, 2'd1, 64'h8);

    // Memory timeout.
    start_machine();
    run_instr(4'h1, 1'b0, 64'h10,  64'h0,   64'h0,  3'b000, 1'b0, 0, 2, 1, 2'd0, 64'h10);
    run_instr(4'h1, 1'b0, 64'h18,  64'h0,   64'h0,  3'b000, 1'b0, 100, 1, 16, 2'd2, 64'h10);

    // Fetch fault priority.
    start_machine();
    run_instr(4'h3, 1'b0, 64'h8,   64'h0,   64'h0,  3'b110, 1'b0, 0, 0, 0, 2'd2, 64'h0);
    start_machine();
    run_instr(4'h3, 1'b0, 64'h8,   64'h0,   64'h0,  3'b010, 1'b0, 0, 0, 0, 2'd3, 64'h0);
    start_machine();
    run_instr(4'h3, 1'b0, 64'h8,   64'h0,   64'h0,  3'b001, 1'b0, 0, 0, 0, 2'd3, 64'h0);

    // Data-memory error after one wait cycle skips writeback.
    start_machine();
    run_instr(4'h5, 1'b0, 64'h8,   64'h0,   64'h0,  3'b000, 1'b1, 1, 1, 2, 2'd2, 64'h0);

    // Asynchronous reset in the middle of MEMORY.
    start_machine();
    run_instr(4'h1, 1'b0, 64'h8,   64'h0,   64'h0,  3'b000, 1'b0, 0, 2, 1, 2'd0, 64'h8);
    Ins_Code = 4'h1;
    Val_P = 64'h20;
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (memory_en) reached = 1'b1;
    end
    chk("reached_memory", {63'd0, reached}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_state", {61'd0, state}, 64'd0);
    chk("midrst_enables", {59'd0, fetch_en, decode_en, execute_en, memory_en, writeback_en}, 64'd0);
    chk("midrst_pc", PC_adress, 64'd0);
    chk("midrst_instr_count", instr_count, 64'd0);
    chk("midrst_cycle_count", {32'd0, cycle_count}, 64'd0);
    chk("midrst_running", {63'd0, running}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_stage_controller.md
Name: seq_stage_controller

Overview:
- Top-level sequencer for the SEQ Y86-64 processor.
- Steps one instruction at a time through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PC-update by issuing one-hot stage enables.
- Owns the architectural PC, the status code (AOK/HLT/ADR/INS) and the instruction/cycle counters.
- Stops the machine on halt or any exception flagged by fetch or data memory.

Parameters:
PC_RESET, 0, PC loaded on start.
MEM_LIMIT, 2400, highest legal PC value; a new PC above this raises ADR.
MEM_TIMEOUT, 16, maximum MEMORY-state wait cycles before ADR.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; starts execution from IDLE or STOP.
Ins_Code  in  4  icode from fetch.
Cnd  in  1  condition result from execute.
Val_P  in  64  fall-through PC from fetch.
Val_C  in  64  constant word from fetch.
Val_M  in  64  value read by memory stage (ret target).
mem_invalid_check  in  1  fetch address error.
instruction_invalid_check  in  1  fetch bad icode.
func_invalid_check  in  1  fetch bad ifun.
mem_ready  in  1  memory stage complete.
dmem_error  in  1  data-memory address error, valid with mem_ready.
PC_adress  out  64  current PC to fetch.
fetch_en, decode_en, execute_en, memory_en, writeback_en  out  1 each  stage enables.
stat  out  2  0=AOK, 1=HLT, 2=ADR, 3=INS.
running  out  1  high outside IDLE/STOP.
done  out  1  high in STOP.
instr_count  out  64  retired instructions.
cycle_count  out  32  cycles since start, saturating at all-ones.
state  out  3  debug state encoding.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state=IDLE; PC_adress=PC_RESET; stat=0; all counters 0; all enables 0; running=0; done=0.
- States and encodings: IDLE 0, FETCH 1, DECODE 2, EXECUTE 3, MEMORY 4, WRITEBACK 5, PCUPD 6, STOP 7.
- start in IDLE or STOP:
  - next state FETCH; PC_adress=PC_RESET; stat=0; instr_count=0; cycle_count=0.
  - start is ignored in every other state.
- Stage enables are combinational from state. Each is high only during its own state:
  - fetch_en in FETCH.
  - decode_en, execute_en: see DECODE gating below.
  - memory_en in every MEMORY cycle.
  - writeback_en in WRITEBACK.
  - No enable is ever high in IDLE, PCUPD or STOP.
- FETCH -> DECODE unconditionally. Fetch outputs are valid from the DECODE cycle.
- DECODE checks, in priority order:
  1. mem_invalid_check -> stat=ADR.
  2. instruction_invalid_check or func_invalid_check -> stat=INS.
  3. Ins_Code==0 -> stat=HLT.
  - On any of these, decode_en is suppressed (0) in that same cycle and the next state is STOP.
  - Otherwise decode_en=1 and the next state is EXECUTE.
- EXECUTE -> MEMORY.
- MEMORY:
  - Waits until mem_ready=1.
  - If dmem_error=1 with mem_ready: stat=ADR, go to STOP, WRITEBACK is skipped.
  - Otherwise go to WRITEBACK.
  - Wait counter resets on entry. If MEM_TIMEOUT cycles elapse with no mem_ready: stat=ADR, go to STOP.
- WRITEBACK -> PCUPD.
- PCUPD selects the new PC:
  - Ins_Code 8 (call) -> Val_C.
  - Ins_Code 7 (jXX) with Cnd=1 -> Val_C.
  - Ins_Code 9 (ret) -> Val_M.
  - All other cases -> Val_P.
  - If the selected PC > MEM_LIMIT (unsigned): stat=ADR, PC is not updated, go to STOP.
  - Otherwise PC_adress takes the new value, instr_count increments, go to FETCH.
- Halted and faulting instructions are not counted.
- PC_adress changes only in PCUPD, on start, or on reset.
- cycle_count increments every cycle while running=1 and saturates.
- STOP holds all outputs until start or rst.
- Minimum latency: 6 cycles per instruction, plus memory wait cycles.

Test Plan:
1. rst, start, nop (Ins_Code=1, Val_P=8) with mem_ready=1 -> enables pulse FETCH..WRITEBACK over 5 consecutive cycles; PC_adress=8 after PCUPD; instr_count=1; cycle_count=6.
2. jXX (Ins_Code=7, Val_C=0x40, Val_P=0x48): Cnd=0 -> PC=0x48; Cnd=1 -> PC=0x40. call -> PC=Val_C. ret with Val_M=0x88 -> PC=0x88.
3. Ins_Code=0 at DECODE -> decode_en=0; stat=1; done=1; PC and instr_count unchanged. A new start pulse restarts at PC_RESET with stat=0.
4. mem_ready low for 3 MEMORY cycles -> memory_en high 4 cycles, then writeback_en. mem_ready never asserted -> stat=2 after 16 cycles, no writeback_en.
5. mem_invalid_check=1 and instruction_invalid_check=1 together -> stat=2 (ADR priority). Only instruction_invalid_check=1 -> stat=3.
6. rst asserted mid-MEMORY -> same cycle: state=0, all enables 0, PC_adress=0, counters 0. New PC=2401 at PCUPD -> stat=2, PC unchanged.
